// File: rtl/mips_fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and the memory (slave).
// The request stays high with a stable address until the memory acknowledges with data.
interface mips_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/mips_fetch_unit.sv
// MIPS fetch unit: owns the PC, fetches one instruction at a time and holds it until retired.
// Optional macro FETCH_TIMEOUT_EN adds an 8-bit fetch timeout that parks the unit in ERR.
module mips_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   mips_fetch_unit_if.master  imem,
   input  logic               advance,
   input  logic [1:0]         sm5,
   input  logic [31:0]        jr_addr,
   output logic [31:0]        instr,
   output logic [5:0]         opcode,
   output logic [5:0]         func,
   output logic               instr_valid,
   output logic [31:0]        pc_plus4,
   output logic               fetch_err
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;
`ifdef FETCH_TIMEOUT_EN
   localparam logic [1:0] ERR   = 2'd3;
`endif

   localparam logic [1:0] SEL_PC4    = 2'b00;
   localparam logic [1:0] SEL_BRANCH = 2'b01;
   localparam logic [1:0] SEL_JUMP   = 2'b10;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic [31:0] nextPc;
   logic [31:0] branchOffset;
`ifdef FETCH_TIMEOUT_EN
   logic [7:0]  cnt_q, cnt_d;
`endif

   assign pc_plus4        = pc_q + 32'd4;
   assign instr           = instr_q;
   assign opcode          = instr_q[31:26];
   assign func            = instr_q[5:0];
   assign instr_valid     = valid_q;
   assign imem.imem_addr  = pc_q;
   // Request is decoded from state so reset drops it without waiting for a clock edge.
   assign imem.imem_req   = (state_q == FETCH);
`ifdef FETCH_TIMEOUT_EN
   assign fetch_err       = (state_q == ERR);
`else
   assign fetch_err       = 1'b0;
`endif

   assign branchOffset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

   always_comb begin
      case (sm5)
         SEL_PC4:    nextPc = pc_plus4;
         SEL_BRANCH: nextPc = pc_plus4 + branchOffset;
         SEL_JUMP:   nextPc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
         default:    nextPc = jr_addr & 32'hFFFF_FFFC;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
`ifdef FETCH_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            state_d = FETCH;
`ifdef FETCH_TIMEOUT_EN
            cnt_d   = 8'd0;
`endif
         end
         FETCH: begin
            if (imem.imem_ack) begin
               instr_d = imem.imem_rdata;
               valid_d = 1'b1;
               state_d = HOLD;
            end
`ifdef FETCH_TIMEOUT_EN
            else begin
               // The 255th unacknowledged cycle is the one that gives up.
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == 8'd254) begin
                  state_d = ERR;
               end
            end
`endif
         end
         HOLD: begin
            if (advance) begin
               pc_d    = nextPc;
               valid_d = 1'b0;
               state_d = FETCH;
`ifdef FETCH_TIMEOUT_EN
               cnt_d   = 8'd0;
`endif
            end
         end
`ifdef FETCH_TIMEOUT_EN
         ERR: begin
            state_d = ERR;
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         instr_q <= 32'd0;
         valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         cnt_q   <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
`ifdef FETCH_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

endmodule

// File: doc/mips_fetch_unit.md
MIPS_FETCH_UNIT -- requirements
Module: mips_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset; asynchronous, active-low.
REQ-004 The block SHALL have port imem_req, output, 1, instruction-memory read request.
REQ-005 The block SHALL have port imem_addr, output, 32, the read address, equal to pc.
REQ-006 The block SHALL have port imem_ack, input, 1, read data valid this cycle.
REQ-007 The block SHALL have port imem_rdata, input, 32, the instruction word.
REQ-008 The block SHALL have port advance, input, 1, current instruction retired; commit next PC.
REQ-009 The block SHALL have port sm5, input, 2, next-PC select from control unit: 00 PC+4, 01 branch, 10 jump, 11 jr.
REQ-010 The block SHALL have port jr_addr, input, 32, register-file value for jr.
REQ-011 The block SHALL have port instr, output, 32, the held instruction register.
REQ-012 The block SHALL have port opcode, output, 6, instr[31:26], for the control unit.
REQ-013 The block SHALL have port func, output, 6, instr[5:0], for the control unit.
REQ-014 The block SHALL have port instr_valid, output, 1, instr holds a fetched, unretired instruction.
REQ-015 The block SHALL have port pc_plus4, output, 32, pc+4 (jal link value).
REQ-016 The block SHALL have port fetch_err, output, 1, fetch timeout flag (see Configuration).

Function
REQ-017 The block SHALL implement the states IDLE, FETCH and HOLD, plus ERR when FETCH_TIMEOUT_EN is defined.
REQ-018 IDLE SHALL go to FETCH unconditionally on the next edge.
REQ-019 In FETCH, imem_req SHALL be 1 and imem_addr SHALL stay stable until the imem_ack cycle.
REQ-020 When imem_ack=1 in FETCH, the block SHALL capture imem_rdata into instr, set instr_valid=1 on the following edge, and go to HOLD (ack-to-valid latency: one cycle).
REQ-021 In HOLD, imem_req SHALL be 0 and instr SHALL hold its value until advance=1.
REQ-022 On advance=1 in HOLD, pc SHALL load next-PC per sm5, instr_valid SHALL clear, and the state SHALL go to FETCH, so the new request issues the next cycle.
REQ-023 Next-PC SHALL be computed as follows: 00 gives pc+4; 01 gives pc+4 + (signext(instr[15:0]) << 2); 10 gives {pc_plus4[31:28], instr[25:0], 2'b00}; 11 gives {jr_addr[31:2], 2'b00}.
REQ-024 All PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-025 The block SHALL ignore advance outside HOLD and imem_ack outside FETCH, and SHALL sample sm5 and jr_addr only on an accepted advance.
REQ-026 opcode, func and pc_plus4 SHALL be combinational from the registers.

Reset
REQ-027 While rst=0, the block SHALL set pc=RESET_PC, state=IDLE, instr=0, instr_valid=0, imem_req=0, fetch_err=0 and timeout counter=0, regardless of clk.
REQ-028 On reset assertion mid-FETCH, the block SHALL drop imem_req immediately (asynchronously), and SHALL ignore any ack that arrives during reset.

Configuration
REQ-029 With macro FETCH_TIMEOUT_EN defined, an 8-bit counter SHALL clear on FETCH entry and increment each FETCH cycle without ack; on reaching 255 the block SHALL go to ERR with fetch_err=1 and imem_req=0, and stay there until reset.
REQ-030 Without FETCH_TIMEOUT_EN, the block SHALL contain no counter and no ERR state, SHALL tie fetch_err to 0, and SHALL let FETCH wait indefinitely.

Verification
REQ-031 Scenario: release rst with RESET_PC=0 and ack two cycles after req -> imem_addr=0, then instr_valid=1 one cycle after ack.
REQ-032 Scenario: pc=0x10 holding beq with imm 0x0003, advance with sm5=01 -> next imem_addr=0x20; with imm 0xFFFF -> next imem_addr=0x10.
REQ-033 Scenario: pc=0x40 holding j with target 0x0000040, advance with sm5=10 -> next imem_addr=0x100.
REQ-034 Scenario: advance with sm5=11 and jr_addr=0x0000_0203 -> next imem_addr=0x200; a separate advance with sm5=00 at pc=0xFFFF_FFFC -> next imem_addr=0.
REQ-035 Scenario: advance pulsed during FETCH and ack pulsed during HOLD -> both ignored; pc and instr are unchanged.
REQ-036 Scenario: with FETCH_TIMEOUT_EN, hold ack=0 for 255 cycles -> fetch_err=1 and imem_req=0; then assert rst mid-FETCH -> all outputs return to their reset values at once.
